mc_seq_ctrl: RTL and testbench
==============================

Name: mc_seq_ctrl

Overview:
- Sequencing controller for the missionary/cannibal river-crossing datapath.
- Owns the bank-state registers: missionaries on the left bank, cannibals on the left bank, and boat side.
- Steps those registers along the canonical 11-crossing solution at a programmable pace, counts moves, and reports the passengers of each crossing.
- Flags completion, or an error when it reaches a state that is off the solution path.
- Sits above the combinational next-state logic and the top-level finish indication.

Parameters:
- STEP_CYCLES, 1: clock cycles per crossing while running; legal range 1..15.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: begin sequencing; sampled only in IDLE.
- abort, input, 1: synchronous return to IDLE with the start state restored; highest priority.
- pause, input, 1: freezes the step timer while in RUN.
- load, input, 1: in IDLE, overwrite the state registers with the load_* values.
- load_m, input, 2: missionaries on the left bank to load.
- load_c, input, 2: cannibals on the left bank to load.
- load_dir, input, 1: boat side to load; 0 = left, 1 = right.
- missionary_cur, output, 2: missionaries on the left bank.
- cannibal_cur, output, 2: cannibals on the left bank.
- direction, output, 1: boat side.
- boat_m, output, 2: missionaries carried by the last crossing.
- boat_c, output, 2: cannibals carried by the last crossing.
- move_cnt, output, 4: crossings committed since the last load, abort or reset.
- busy, output, 1: high in RUN.
- finish, output, 1: high in DONE.
- error, output, 1: high in ERR.

Behaviour:
- Reset (async, reset=0):
  - FSM = IDLE.
  - State = (m=3, c=3, dir=0).
  - move_cnt = 0, boat_m = 0, boat_c = 0, timer = 0.
  - busy, finish, error = 0.
  - Takes effect immediately, including mid-RUN.
- FSM states: IDLE, RUN, DONE, ERR. All transitions are on the clk rising edge.
- abort=1 in any state: next state is IDLE, with all registers at their reset values.
- IDLE:
  - load=1 has priority over start. It loads (load_m, load_c, load_dir), clears move_cnt and boat_*, and stays in IDLE.
  - start=1 with load=0:
    - If the current state is the goal (0,0,1), go to DONE; move_cnt is unchanged.
    - Otherwise go to RUN, with timer = STEP_CYCLES-1.
- RUN:
  - pause=1: timer holds and no crossing occurs.
  - pause=0 and timer != 0: timer decrements.
  - pause=0 and timer == 0: look up the successor of the current state.
    - Valid successor: commit the new state; move_cnt += 1 (saturates at 15); boat_m = |new m − old m|; boat_c = |new c − old c|; dir toggles.
    - If the new state is the goal, go to DONE. Otherwise reload timer with STEP_CYCLES-1.
    - No successor: go to ERR; state, move_cnt and boat_* hold.
  - start and load are ignored in RUN.
- Successor table, written as (m,c,dir) → next. Any other state has no successor.
  - (3,3,0) → (3,1,1)
  - (3,1,1) → (3,2,0)
  - (3,2,0) → (3,0,1)
  - (3,0,1) → (3,1,0)
  - (3,1,0) → (1,1,1)
  - (1,1,1) → (2,2,0)
  - (2,2,0) → (0,2,1)
  - (0,2,1) → (0,3,0)
  - (0,3,0) → (0,1,1)
  - (0,1,1) → (0,2,0)
  - (0,2,0) → (0,0,1)
- DONE: finish=1 and all outputs hold. start and load are ignored; only abort or reset leaves DONE.
- ERR: error=1 and all outputs hold. Only abort or reset leaves ERR.
- Timing:
  - start sampled at edge N.
  - busy=1 after edge N.
  - The k-th crossing commits at edge N + k·STEP_CYCLES, counting only cycles with pause=0.
  - From the start state: finish=1 and busy=0 after edge N + 11·STEP_CYCLES, with move_cnt = 11.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package mc_pkg holds:
  - State struct {m[1:0], c[1:0], dir}.
  - Constants MC_START = (3,3,0), MC_GOAL = (0,0,1), MC_MOVES = 11.
  - FSM state enum.
- Sub-module mc_next_state (combinational):
  - Input: current state struct.
  - Outputs: next state struct and a valid bit, implementing the successor table.
- mc_seq_ctrl contains the FSM, the timer, the state, move_cnt and boat_* registers, and the absolute-difference logic.

Test Plan:
1. Reset, then start pulse, STEP_CYCLES=1 → states step through the table once per cycle. finish=1 exactly 11 cycles after start is sampled; move_cnt=11; final state (0,0,1); at crossing 6, boat_m=1 and boat_c=1.
2. STEP_CYCLES=3, with pause=1 for 4 cycles before crossing 2 → crossing 1 at +3 cycles, crossing 2 at +10 cycles. busy stays 1 throughout the pause and the state holds.
3. Load (2,1,0), then start → at the first step, ERR with error=1; state holds at (2,1,0) and move_cnt=0. abort → IDLE, state (3,3,0), error=0.
4. Load (0,2,0), then start → one crossing to (0,0,1); finish=1, move_cnt=1, boat_c=2, boat_m=0. Load the goal (0,0,1), then start → DONE next cycle with move_cnt=0.
5. reset=0 asserted mid-run after crossing 5 → outputs go immediately (asynchronously) to their reset values: state (3,3,0), move_cnt=0, busy=0.
6. Simultaneous start+load in IDLE → load wins and FSM stays IDLE. Simultaneous abort+start in IDLE → IDLE with start state restored. start in DONE → ignored, finish stays 1.

Source files
------------

// File: rtl/mc_pkg.sv
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and constants for the missionary/cannibal
//               river-crossing sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef struct packed {
        logic [1:0] m;
        logic [1:0] c;
        logic       dir;
    } mc_state_t;

    localparam mc_state_t  MC_START = '{m: 2'd3, c: 2'd3, dir: 1'b0};
    localparam mc_state_t  MC_GOAL  = '{m: 2'd0, c: 2'd0, dir: 1'b1};
    localparam logic [3:0] MC_MOVES = 4'd11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    function automatic logic [1:0] mc_absdiff(input logic [1:0] a, input logic [1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_next_state.sv
// ============================================================================
// Module      : mc_next_state
// Description : Successor lookup along the canonical 11-crossing solution.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_next_state
    import mc_pkg::*;
(
    input  mc_state_t cur_i,
    output mc_state_t nxt_o,
    output logic      valid_o
);

    always_comb begin
        nxt_o   = cur_i;
        valid_o = 1'b1;
        case ({cur_i.m, cur_i.c, cur_i.dir})
            5'b11_11_0: nxt_o = '{m: 2'd3, c: 2'd1, dir: 1'b1};
            5'b11_01_1: nxt_o = '{m: 2'd3, c: 2'd2, dir: 1'b0};
            5'b11_10_0: nxt_o = '{m: 2'd3, c: 2'd0, dir: 1'b1};
            5'b11_00_1: nxt_o = '{m: 2'd3, c: 2'd1, dir: 1'b0};
            5'b11_01_0: nxt_o = '{m: 2'd1, c: 2'd1, dir: 1'b1};
            5'b01_01_1: nxt_o = '{m: 2'd2, c: 2'd2, dir: 1'b0};
            5'b10_10_0: nxt_o = '{m: 2'd0, c: 2'd2, dir: 1'b1};
            5'b00_10_1: nxt_o = '{m: 2'd0, c: 2'd3, dir: 1'b0};
            5'b00_11_0: nxt_o = '{m: 2'd0, c: 2'd1, dir: 1'b1};
            5'b00_01_1: nxt_o = '{m: 2'd0, c: 2'd2, dir: 1'b0};
            5'b00_10_0: nxt_o = '{m: 2'd0, c: 2'd0, dir: 1'b1};
            default:    valid_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_seq_ctrl.sv
// ============================================================================
// Module      : mc_seq_ctrl
// Description : Paced sequencer stepping the bank state along the solution.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_seq_ctrl
    import mc_pkg::*;
#(
    parameter int STEP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    input  logic       load,
    input  logic [1:0] load_m,
    input  logic [1:0] load_c,
    input  logic       load_dir,
    output logic [1:0] missionary_cur,
    output logic [1:0] cannibal_cur,
    output logic       direction,
    output logic [1:0] boat_m,
    output logic [1:0] boat_c,
    output logic [3:0] move_cnt,
    output logic       busy,
    output logic       finish,
    output logic       error
);

    localparam logic [3:0] RELOAD = 4'(STEP_CYCLES - 1);

    logic [1:0] fsm_q, fsm_d;
    mc_state_t  st_q, st_d;
    logic [3:0] timer_q, timer_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] bm_q, bm_d;
    logic [1:0] bc_q, bc_d;
    logic       busy_q, finish_q, error_q;

    mc_state_t  nxt;
    logic       nxt_valid;

    mc_next_state u_next (
        .cur_i   (st_q),
        .nxt_o   (nxt),
        .valid_o (nxt_valid)
    );

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        bm_d    = bm_q;
        bc_d    = bc_q;
        if (abort) begin
            fsm_d   = ST_IDLE;
            st_d    = MC_START;
            timer_d = 4'd0;
            cnt_d   = 4'd0;
            bm_d    = 2'd0;
            bc_d    = 2'd0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (load) begin
                        st_d  = '{m: load_m, c: load_c, dir: load_dir};
                        cnt_d = 4'd0;
                        bm_d  = 2'd0;
                        bc_d  = 2'd0;
                    end else if (start) begin
                        if (st_q == MC_GOAL) begin
                            fsm_d = ST_DONE;
                        end else begin
                            fsm_d   = ST_RUN;
                            timer_d = RELOAD;
                        end
                    end
                end
                ST_RUN: begin
                    if (!pause) begin
                        if (timer_q != 4'd0) begin
                            timer_d = timer_q - 4'd1;
                        end else if (nxt_valid) begin
                            st_d  = nxt;
                            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                            bm_d  = mc_absdiff(nxt.m, st_q.m);
                            bc_d  = mc_absdiff(nxt.c, st_q.c);
                            if (nxt == MC_GOAL) begin
                                fsm_d = ST_DONE;
                            end else begin
                                timer_d = RELOAD;
                            end
                        end else begin
                            // Off-path state: freeze everything for inspection
                            fsm_d = ST_ERR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q    <= ST_IDLE;
            st_q     <= MC_START;
            timer_q  <= 4'd0;
            cnt_q    <= 4'd0;
            bm_q     <= 2'd0;
            bc_q     <= 2'd0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            st_q     <= st_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            bm_q     <= bm_d;
            bc_q     <= bc_d;
            busy_q   <= (fsm_d == ST_RUN);
            finish_q <= (fsm_d == ST_DONE);
            error_q  <= (fsm_d == ST_ERR);
        end
    end

    assign missionary_cur = st_q.m;
    assign cannibal_cur   = st_q.c;
    assign direction      = st_q.dir;
    assign boat_m         = bm_q;
    assign boat_c         = bc_q;
    assign move_cnt       = cnt_q;
    assign busy           = busy_q;
    assign finish         = finish_q;
    assign error          = error_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_seq_ctrl.sv
// ============================================================================
// Module      : tb_mc_seq_ctrl
// Description : Self-checking bench for mc_seq_ctrl (pace 1 and pace 3 units).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_seq_ctrl;

    typedef struct packed {
        logic [4:0] st;
        logic [1:0] bm;
        logic [1:0] bc;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, abort = 1'b0, pause = 1'b0, load = 1'b0;
    logic [1:0] load_m = 2'd0, load_c = 2'd0;
    logic       load_dir = 1'b0;

    logic [1:0] d1_m, d1_c, d1_bm, d1_bc, d3_m, d3_c, d3_bm, d3_bc;
    logic       d1_dir, d1_busy, d1_fin, d1_err, d3_dir, d3_busy, d3_fin, d3_err;
    logic [3:0] d1_cnt, d3_cnt;

    int   passed = 0;
    int   total  = 0;
    exp_t sb[$];
    logic [4:0] sol [12];

    always #5 clk = ~clk;

    mc_seq_ctrl #(.STEP_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
        .load(load), .load_m(load_m), .load_c(load_c), .load_dir(load_dir),
        .missionary_cur(d1_m), .cannibal_cur(d1_c), .direction(d1_dir),
        .boat_m(d1_bm), .boat_c(d1_bc), .move_cnt(d1_cnt),
        .busy(d1_busy), .finish(d1_fin), .error(d1_err)
    );

    mc_seq_ctrl #(.STEP_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
        .load(load), .load_m(load_m), .load_c(load_c), .load_dir(load_dir),
        .missionary_cur(d3_m), .cannibal_cur(d3_c), .direction(d3_dir),
        .boat_m(d3_bm), .boat_c(d3_bc), .move_cnt(d3_cnt),
        .busy(d3_busy), .finish(d3_fin), .error(d3_err)
    );

    function automatic logic [1:0] adiff(input logic [1:0] a, input logic [1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic exp_t mk_exp(input int k);
        exp_t e;
        e.st  = sol[k];
        e.bm  = adiff(sol[k][4:3], sol[k-1][4:3]);
        e.bc  = adiff(sol[k][2:1], sol[k-1][2:1]);
        e.cnt = 4'(k);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #7;
        total++;
        if ({d1_m, d1_c, d1_dir, d1_bm, d1_bc, d1_cnt, d1_busy, d1_fin, d1_err} !== 16'b11_11_0_00_00_0000_000)
            $display("FAIL reset_state got=%0h exp=%0h",
                     {d1_m, d1_c, d1_dir, d1_bm, d1_bc, d1_cnt, d1_busy, d1_fin, d1_err}, 16'b11_11_0_00_00_0000_000);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_solution();
        exp_t e;
        for (int k = 1; k <= 11; k++) sb.push_back(mk_exp(k));
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({d1_busy, d1_fin} !== 2'b10) $display("FAIL sol_busy got=%b exp=10", {d1_busy, d1_fin});
        else passed++;
        for (int k = 1; k <= 11; k++) begin
            tick();
            e = sb.pop_front();
            total++;
            if ({d1_m, d1_c, d1_dir, d1_bm, d1_bc, d1_cnt} !== {e.st, e.bm, e.bc, e.cnt})
                $display("FAIL sol_step%0d got=%0h exp=%0h", k,
                         {d1_m, d1_c, d1_dir, d1_bm, d1_bc, d1_cnt}, {e.st, e.bm, e.bc, e.cnt});
            else passed++;
            total++;
            if ({d1_busy, d1_fin} !== ((k < 11) ? 2'b10 : 2'b01))
                $display("FAIL sol_flags%0d got=%b exp=%b", k, {d1_busy, d1_fin}, (k < 11) ? 2'b10 : 2'b01);
            else passed++;
            if (k == 6) begin
                total++;
                if ({d1_bm, d1_bc} !== 4'b01_01) $display("FAIL sol_boat6 got=%b exp=0101", {d1_bm, d1_bc});
                else passed++;
            end
        end
    endtask

    task automatic test_pause();
        exp_t e;
        pulse_abort();
        sb.push_back(mk_exp(1));
        sb.push_back(mk_exp(2));
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({d3_m, d3_c, d3_dir, d3_cnt, d3_busy} !== {5'b11110, 4'd0, 1'b1})
                $display("FAIL pace_wait%0d got=%0h exp=%0h", i, {d3_m, d3_c, d3_dir, d3_cnt, d3_busy}, {5'b11110, 4'd0, 1'b1});
            else passed++;
        end
        tick();
        e = sb.pop_front();
        total++;
        if ({d3_m, d3_c, d3_dir, d3_bm, d3_bc, d3_cnt} !== {e.st, e.bm, e.bc, e.cnt})
            $display("FAIL pace_cross1 got=%0h exp=%0h", {d3_m, d3_c, d3_dir, d3_bm, d3_bc, d3_cnt}, {e.st, e.bm, e.bc, e.cnt});
        else passed++;
        pause = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) pause = 1'b0;
            tick();
            total++;
            if ({d3_m, d3_c, d3_dir, d3_cnt, d3_busy} !== {5'b11011, 4'd1, 1'b1})
                $display("FAIL pace_hold%0d got=%0h exp=%0h", i, {d3_m, d3_c, d3_dir, d3_cnt, d3_busy}, {5'b11011, 4'd1, 1'b1});
            else passed++;
        end
        tick();
        e = sb.pop_front();
        total++;
        if ({d3_m, d3_c, d3_dir, d3_bm, d3_bc, d3_cnt} !== {e.st, e.bm, e.bc, e.cnt})
            $display("FAIL pace_cross2 got=%0h exp=%0h", {d3_m, d3_c, d3_dir, d3_bm, d3_bc, d3_cnt}, {e.st, e.bm, e.bc, e.cnt});
        else passed++;
    endtask

    task automatic do_load(input logic [1:0] m, input logic [1:0] c, input logic d);
        load_m = m; load_c = c; load_dir = d; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_error();
        pulse_abort();
        do_load(2'd2, 2'd1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if ({d1_m, d1_c, d1_dir, d1_cnt, d1_busy, d1_err} !== {5'b10010, 4'd0, 2'b01})
            $display("FAIL err_enter got=%0h exp=%0h", {d1_m, d1_c, d1_dir, d1_cnt, d1_busy, d1_err}, {5'b10010, 4'd0, 2'b01});
        else passed++;
        tick();
        total++;
        if ({d1_m, d1_c, d1_dir, d1_err} !== {5'b10010, 1'b1})
            $display("FAIL err_hold got=%0h exp=%0h", {d1_m, d1_c, d1_dir, d1_err}, {5'b10010, 1'b1});
        else passed++;
        pulse_abort();
        total++;
        if ({d1_m, d1_c, d1_dir, d1_err, d1_busy} !== {5'b11110, 2'b00})
            $display("FAIL err_abort got=%0h exp=%0h", {d1_m, d1_c, d1_dir, d1_err, d1_busy}, {5'b11110, 2'b00});
        else passed++;
    endtask

    task automatic test_short_and_goal();
        pulse_abort();
        do_load(2'd0, 2'd2, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if ({d1_m, d1_c, d1_dir, d1_bm, d1_bc, d1_cnt, d1_fin, d1_busy} !== {5'b00001, 2'd0, 2'd2, 4'd1, 2'b10})
            $display("FAIL one_move got=%0h exp=%0h", {d1_m, d1_c, d1_dir, d1_bm, d1_bc, d1_cnt, d1_fin, d1_busy},
                     {5'b00001, 2'd0, 2'd2, 4'd1, 2'b10});
        else passed++;
        pulse_abort();
        do_load(2'd0, 2'd0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({d1_fin, d1_busy, d1_cnt} !== {2'b10, 4'd0})
            $display("FAIL goal_start got=%0h exp=%0h", {d1_fin, d1_busy, d1_cnt}, {2'b10, 4'd0});
        else passed++;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if ({d1_fin, d1_busy, d1_cnt, d1_m, d1_c, d1_dir} !== {2'b10, 4'd0, 5'b00001})
            $display("FAIL done_ignore_start got=%0h exp=%0h", {d1_fin, d1_busy, d1_cnt, d1_m, d1_c, d1_dir}, {2'b10, 4'd0, 5'b00001});
        else passed++;
    endtask

    task automatic test_async_reset();
        pulse_abort();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        total++;
        if ({d1_cnt, d1_m, d1_c, d1_dir} !== {4'd5, sol[5]})
            $display("FAIL mid_run5 got=%0h exp=%0h", {d1_cnt, d1_m, d1_c, d1_dir}, {4'd5, sol[5]});
        else passed++;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({d1_m, d1_c, d1_dir, d1_cnt, d1_busy, d1_bm, d1_bc} !== {5'b11110, 4'd0, 1'b0, 4'd0})
            $display("FAIL async_reset got=%0h exp=%0h", {d1_m, d1_c, d1_dir, d1_cnt, d1_busy, d1_bm, d1_bc},
                     {5'b11110, 4'd0, 1'b0, 4'd0});
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_priority();
        pulse_abort();
        load_m = 2'd0; load_c = 2'd2; load_dir = 1'b0;
        load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        total++;
        if ({d1_m, d1_c, d1_dir, d1_busy, d1_cnt} !== {5'b00100, 1'b0, 4'd0})
            $display("FAIL load_over_start got=%0h exp=%0h", {d1_m, d1_c, d1_dir, d1_busy, d1_cnt}, {5'b00100, 1'b0, 4'd0});
        else passed++;
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        total++;
        if ({d1_m, d1_c, d1_dir, d1_busy, d1_fin} !== {5'b11110, 2'b00})
            $display("FAIL abort_over_start got=%0h exp=%0h", {d1_m, d1_c, d1_dir, d1_busy, d1_fin}, {5'b11110, 2'b00});
        else passed++;
    endtask

    initial begin
        sol = '{5'b11110, 5'b11011, 5'b11100, 5'b11001, 5'b11010, 5'b01011,
                5'b10100, 5'b00101, 5'b00110, 5'b00011, 5'b00100, 5'b00001};
        test_reset();
        test_solution();
        test_pause();
        test_error();
        test_short_and_goal();
        test_async_reset();
        test_priority();
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
